// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Index width for n requesters. Never returns less than 1, so a
    // two-requester build still gets a usable index bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker. It scans from last+1 upward and wraps
// modulo NREQ. It returns the first requester it finds, with the winner
// given both as an index and as a one-hot vector.
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic            o_valid,
    output logic [IW-1:0]   o_winner,
    output logic [NREQ-1:0] o_onehot
);

    // The scan runs from the farthest candidate to the nearest. The last hit
    // is therefore the requester closest after the pointer.
    always_comb begin
        logic [IW-1:0] w_idx;
        w_idx    = '0;
        o_valid  = 1'b0;
        o_winner = '0;
        o_onehot = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = IW'((int'(i_last) + k) % NREQ);
            if (i_req[w_idx]) begin
                o_valid  = 1'b1;
                o_winner = w_idx;
            end
        end
        if (o_valid) begin
            o_onehot = NREQ'(1) << o_winner;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter and its single shared WIDTH-bit register.
// Each grant loads the winner's data, pulses gnt for one cycle, and then
// enforces HOLD_CYC guard cycles before the next arbitration.
// Optional macro REG_ARB_LOCK_EN adds a `lock` input. While lock is set, the
// last winner is regranted for as long as it keeps requesting.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter  int NREQ     = 4,
    parameter  int WIDTH    = 8,
    parameter  int HOLD_CYC = 2,
    localparam int IW       = idx_w(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef REG_ARB_LOCK_EN
    input  logic                  lock,
`endif
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [IW-1:0]         grant_id,
    output logic [WIDTH-1:0]      q,
    output logic                  busy
);

    localparam logic [7:0] HOLD_LD = 8'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_cnt;
    logic [IW-1:0]     r_last;
    logic [NREQ-1:0]   r_gnt;
    logic [IW-1:0]     r_grant_id;
    logic [WIDTH-1:0]  r_q;

    logic              w_pick_valid;
    logic [IW-1:0]     w_pick_id;
    logic [NREQ-1:0]   w_pick_oh;
    logic              w_lock_hit;
    logic [IW-1:0]     w_win;
    logic [NREQ-1:0]   w_win_oh;
    logic              w_do_grant;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .i_req    (req),
        .i_last   (r_last),
        .o_valid  (w_pick_valid),
        .o_winner (w_pick_id),
        .o_onehot (w_pick_oh)
    );

`ifdef REG_ARB_LOCK_EN
    assign w_lock_hit = lock && req[r_last];
`else
    assign w_lock_hit = 1'b0;
`endif

    // A lock hit regrants the previous winner, so the pointer stays where it is.
    assign w_win    = w_lock_hit ? r_last : w_pick_id;
    assign w_win_oh = w_lock_hit ? (NREQ'(1) << r_last) : w_pick_oh;

    // Next-state logic: arbitrate only in IDLE, then one GRANT cycle, then the guard.
    always_comb begin
        w_state_nxt = r_state;
        w_do_grant  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = GRANT;
                    w_do_grant  = 1'b1;
                end
            end
            GRANT:   w_state_nxt = (HOLD_CYC == 0) ? IDLE : HOLD;
            HOLD:    if (r_cnt == 8'd0) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Grant pulse, shared register write, pointer update and guard counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt      <= '0;
            r_q        <= '0;
            r_grant_id <= '0;
            r_last     <= IW'(NREQ - 1);
            r_cnt      <= 8'd0;
        end else begin
            r_gnt <= w_do_grant ? w_win_oh : '0;
            if (w_do_grant) begin
                r_q        <= wdata[int'(w_win)*WIDTH +: WIDTH];
                r_grant_id <= w_win;
                r_last     <= w_win;
            end
            if (r_state == GRANT)
                r_cnt <= HOLD_LD;
            else if (r_state == HOLD && r_cnt != 8'd0)
                r_cnt <= r_cnt - 8'd1;
        end
    end

    assign gnt      = r_gnt;
    assign grant_id = r_grant_id;
    assign q        = r_q;
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter. One instance uses HOLD_CYC=2 and a
// second uses HOLD_CYC=0. Expected grants are queued as stimulus is applied
// and popped as the DUT issues each grant.
module tb_reg_write_arbiter;

    typedef struct packed {
        logic [3:0] g;
        logic [7:0] d;
        logic [1:0] id;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        lock;
    logic [3:0]  req, req0;
    logic [31:0] wdata, wdata0;
    logic [3:0]  gnt, gnt0;
    logic [1:0]  gid, gid0;
    logic [7:0]  q, q0;
    logic        busy, busy0;

    exp_t sb[$];
    exp_t sb0[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    reg_write_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_CYC(2)) u_dut (
        .clk      (clk),
        .reset    (reset),
`ifdef REG_ARB_LOCK_EN
        .lock     (lock),
`endif
        .req      (req),
        .wdata    (wdata),
        .gnt      (gnt),
        .grant_id (gid),
        .q        (q),
        .busy     (busy)
    );

    reg_write_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_CYC(0)) u_dut0 (
        .clk      (clk),
        .reset    (reset),
`ifdef REG_ARB_LOCK_EN
        .lock     (1'b0),
`endif
        .req      (req0),
        .wdata    (wdata0),
        .gnt      (gnt0),
        .grant_id (gid0),
        .q        (q0),
        .busy     (busy0)
    );

    function automatic exp_t mk(input int id, input logic [7:0] d);
        exp_t e;
        e.g  = 4'(1 << id);
        e.d  = d;
        e.id = 2'(id);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advances until the selected DUT shows a grant, or until the limit runs out.
    task automatic wait_gnt(input bit which, input int limit, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (((which ? gnt0 : gnt) == 4'b0) && cyc < limit);
        if ((which ? gnt0 : gnt) == 4'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_gnt%0d: no grant within %0d cycles", which, limit);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        req   = 4'b0;
        req0  = 4'b0;
        lock  = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        lock  = 1'b0;
        req   = 4'b1111;
        req0  = 4'b1111;
        wdata = 32'hDEADBEEF;
        wdata0 = 32'hDEADBEEF;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_vec++;
            if (gnt !== 4'b0 || q !== 8'h00 || busy !== 1'b0 || gid !== 2'd0) begin
                n_err++;
                $display("FAIL reset[%0d]: gnt=%b q=%h busy=%b id=%0d, expected 0000/00/0/0",
                         c, gnt, q, busy, gid);
            end
            n_vec++;
            if (gnt0 !== 4'b0 || q0 !== 8'h00 || busy0 !== 1'b0) begin
                n_err++;
                $display("FAIL reset0[%0d]: gnt=%b q=%h busy=%b, expected 0000/00/0", c, gnt0, q0, busy0);
            end
        end
        req   = 4'b0;
        req0  = 4'b0;
        reset = 1'b0;
        tick();
        n_vec++;
        if (busy !== 1'b0 || gnt !== 4'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: busy=%b gnt=%b, expected 0/0000", busy, gnt);
        end
    endtask

    task automatic test_single();
        exp_t e;
        wdata = 32'h0000_A500;
        req   = 4'b0010;
        sb.push_back(mk(1, 8'hA5));
        tick();
        req = 4'b0;
        e = sb.pop_front();
        n_vec++;
        if (gnt !== e.g || q !== e.d || gid !== e.id || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_grant: gnt=%b q=%h id=%0d busy=%b, expected %b/%h/%0d/1",
                     gnt, q, gid, busy, e.g, e.d, e.id);
        end
        wdata = 32'h5555_5555;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++;
            if (busy !== (c < 2) || gnt !== 4'b0 || q !== 8'hA5 || gid !== 2'd1) begin
                n_err++;
                $display("FAIL single_hold[%0d]: busy=%b gnt=%b q=%h id=%0d, expected %b/0000/a5/1",
                         c, busy, gnt, q, gid, (c < 2));
            end
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   cyc;
        pulse_reset();
        wdata = 32'h1312_1110;
        req   = 4'b1111;
        for (int i = 0; i < 5; i++) sb.push_back(mk(i % 4, 8'h10 + 8'(i % 4)));
        for (int i = 0; i < 5; i++) begin
            wait_gnt(1'b0, 10, cyc);
            e = sb.pop_front();
            n_vec++;
            if (gnt !== e.g || q !== e.d || gid !== e.id) begin
                n_err++;
                $display("FAIL rr_grant[%0d]: gnt=%b q=%h id=%0d, expected %b/%h/%0d",
                         i, gnt, q, gid, e.g, e.d, e.id);
            end
            n_vec++;
            if (cyc !== ((i == 0) ? 1 : 4)) begin
                n_err++;
                $display("FAIL rr_spacing[%0d]: %0d cycles, expected %0d", i, cyc, (i == 0) ? 1 : 4);
            end
        end
        req = 4'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset_mid_hold();
        exp_t e;
        pulse_reset();
        wdata = 32'h0077_0000;
        req   = 4'b0100;
        sb.push_back(mk(2, 8'h77));
        tick();
        req = 4'b0;
        e = sb.pop_front();
        n_vec++;
        if (gnt !== e.g || q !== e.d || gid !== e.id) begin
            n_err++;
            $display("FAIL mid_grant: gnt=%b q=%h id=%0d, expected %b/%h/%0d", gnt, q, gid, e.g, e.d, e.id);
        end
        tick();
        reset = 1'b1;
        req   = 4'b1001;
        wdata = 32'h9900_003C;
        tick();
        n_vec++;
        if (busy !== 1'b0 || q !== 8'h00 || gnt !== 4'b0 || gid !== 2'd0) begin
            n_err++;
            $display("FAIL mid_reset: busy=%b q=%h gnt=%b id=%0d, expected 0/00/0000/0", busy, q, gnt, gid);
        end
        reset = 1'b0;
        sb.push_back(mk(0, 8'h3C));
        tick();
        req = 4'b0;
        e = sb.pop_front();
        n_vec++;
        if (gnt !== e.g || q !== e.d || gid !== e.id) begin
            n_err++;
            $display("FAIL ptr_reset: gnt=%b q=%h id=%0d, expected %b/%h/%0d", gnt, q, gid, e.g, e.d, e.id);
        end
        repeat (4) tick();
    endtask

    task automatic test_hold0();
        exp_t e;
        int   cyc;
        wdata0 = 32'h0023_0021;
        req0   = 4'b0101;
        for (int i = 0; i < 4; i++) sb0.push_back((i % 2 == 0) ? mk(0, 8'h21) : mk(2, 8'h23));
        for (int i = 0; i < 4; i++) begin
            wait_gnt(1'b1, 6, cyc);
            e = sb0.pop_front();
            n_vec++;
            if (gnt0 !== e.g || q0 !== e.d || gid0 !== e.id) begin
                n_err++;
                $display("FAIL hold0_grant[%0d]: gnt=%b q=%h id=%0d, expected %b/%h/%0d",
                         i, gnt0, q0, gid0, e.g, e.d, e.id);
            end
            n_vec++;
            if (cyc !== ((i == 0) ? 1 : 2)) begin
                n_err++;
                $display("FAIL hold0_spacing[%0d]: %0d cycles, expected %0d", i, cyc, (i == 0) ? 1 : 2);
            end
        end
        req0 = 4'b0;
        repeat (2) tick();
    endtask

`ifdef REG_ARB_LOCK_EN
    task automatic test_lock();
        exp_t e;
        int   cyc;
        pulse_reset();
        wdata = 32'h0000_4140;
        lock  = 1'b1;
        req   = 4'b0011;
        for (int i = 0; i < 3; i++) sb.push_back(mk(0, 8'h40));
        sb.push_back(mk(1, 8'h41));
        for (int i = 0; i < 4; i++) begin
            wait_gnt(1'b0, 10, cyc);
            if (i == 2) lock = 1'b0;
            e = sb.pop_front();
            n_vec++;
            if (gnt !== e.g || q !== e.d || gid !== e.id) begin
                n_err++;
                $display("FAIL lock_grant[%0d]: gnt=%b q=%h id=%0d, expected %b/%h/%0d",
                         i, gnt, q, gid, e.g, e.d, e.id);
            end
        end
        req = 4'b0;
        repeat (4) tick();
    endtask
`endif

    initial begin
        reset  = 1'b1;
        lock   = 1'b0;
        req    = 4'b0;
        req0   = 4'b0;
        wdata  = 32'h0;
        wdata0 = 32'h0;
        test_reset();
        test_single();
        test_round_robin();
        test_reset_mid_hold();
        test_hold0();
`ifdef REG_ARB_LOCK_EN
        test_lock();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
